// File: rtl/prog_sequencer.sv
// Program counter sequencer with a small hardware return stack for calls/returns.
// Redirects take effect on the next clock; an all-ones opcode halts the sequencer until reset.
module prog_sequencer #(
  parameter int D = 10,
  parameter int W = 9,
  parameter int S = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [W-1:0]               mach_code,
  input  logic                       absj_en,
  input  logic [D-1:0]               target,
  input  logic                       relj_en,
  input  logic                       br_cond,
  input  logic [D-1:0]               offset,
  input  logic                       call_en,
  input  logic                       ret_en,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(S+1)-1:0]     sp,
  output logic                       stack_ovf,
  output logic                       stack_unf,
  output logic                       done
);
  localparam int SPW = $clog2(S+1);
  localparam int AW  = $clog2(S);

  logic [D-1:0]   pc_q, pc_d, pc_inc;
  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic           ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
  logic           push;
  logic [AW-1:0]  push_idx, pop_idx;
  logic [D-1:0]   stk_q [S];

  assign pc_inc   = pc_q + D'(1);
  assign sp_m1    = sp_q - SPW'(1);
  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = sp_m1[AW-1:0];

  // Halt outranks every request; all arithmetic wraps at D bits.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    done_d = done_q;
    push   = 1'b0;
    if (!done_q && !stall) begin
      if (&mach_code) begin
        done_d = 1'b1;
      end else if (ret_en) begin
        if (sp_q != '0) begin
          pc_d = stk_q[pop_idx];
          sp_d = sp_m1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        if (sp_q != SPW'(S)) begin
          push = 1'b1;
          pc_d = target;
          sp_d = sp_q + SPW'(1);
        end else begin
          pc_d  = pc_inc;
          ovf_d = 1'b1;
        end
      end else if (absj_en) begin
        pc_d = target;
      end else if (relj_en && br_cond) begin
        pc_d = pc_q + offset;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      done_q <= done_d;
    end
  end

  // Stack entries need no reset: sp=0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (push) stk_q[push_idx] <= pc_inc;
  end

  assign prog_ctr  = pc_q;
  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  assign done      = done_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench: stimulus queues expected post-edge state, a monitor compares after each edge.
module tb_prog_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       stall, absj_en, relj_en, br_cond, call_en, ret_en;
  logic [8:0] mach_code;
  logic [9:0] target, offset;
  logic [9:0] prog_ctr;
  logic [1:0] sp;
  logic       stack_ovf, stack_unf, done;

  logic [3:0] w_pc;
  logic [2:0] w_sp;
  logic       w_ovf, w_unf, w_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;
    logic [9:0] pc;
    logic [1:0] sp;
    logic       ovf, unf, dn;
    string      nm;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  prog_sequencer #(.D(10), .W(9), .S(2)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .mach_code(mach_code),
    .absj_en(absj_en), .target(target), .relj_en(relj_en), .br_cond(br_cond),
    .offset(offset), .call_en(call_en), .ret_en(ret_en),
    .prog_ctr(prog_ctr), .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf), .done(done));

  prog_sequencer #(.D(4), .W(9), .S(4)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .mach_code(9'h000),
    .absj_en(1'b0), .target(4'h0), .relj_en(1'b0), .br_cond(1'b0),
    .offset(4'h0), .call_en(1'b0), .ret_en(1'b0),
    .prog_ctr(w_pc), .sp(w_sp), .stack_ovf(w_ovf), .stack_unf(w_unf), .done(w_done));

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: state is presented every cycle, so compare after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel)
          chk(e.nm, {3'd0, w_sp, w_pc, w_ovf, w_unf, w_done, 3'd0},
                    {3'd0, 3'd0, e.pc[3:0], 1'b0, 1'b0, 1'b0, 3'd0});
        else
          chk(e.nm, {prog_ctr, sp, stack_ovf, stack_unf, done, 1'b0},
                    {e.pc, e.sp, e.ovf, e.unf, e.dn, 1'b0});
      end
    end
  end

  task automatic clr();
    stall = 0; mach_code = 9'h000; absj_en = 0; target = '0; relj_en = 0;
    br_cond = 0; offset = '0; call_en = 0; ret_en = 0;
  endtask

  task automatic tick(input bit sel, input logic [9:0] pc, input logic [1:0] s,
                      input logic o, input logic u, input logic dn, input string nm);
    exp_t e;
    e.sel = sel; e.pc = pc; e.sp = s; e.ovf = o; e.unf = u; e.dn = dn; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b0;
    #1;
    chk("reset_main", {prog_ctr, sp, stack_ovf, stack_unf, done, 1'b0}, 16'h0000);
    chk("reset_wrap", {7'd0, w_pc, w_sp, w_done, w_ovf}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Sequential wrap with D=4.
    for (int k = 1; k <= 16; k++)
      tick(1'b1, 10'(k % 16), 2'd0, 0, 0, 0, $sformatf("wrap%0d", k));

    // Restart mid-program.
    reset = 1'b0; #1; reset = 1'b1;

    absj_en = 1; target = 10'd5;                   tick(0, 10'd5,  2'd0, 0, 0, 0, "absj5");
    relj_en = 1; br_cond = 1; offset = 10'h3FD;    tick(0, 10'd2,  2'd0, 0, 0, 0, "rel_taken");
    absj_en = 1; target = 10'd5;                   tick(0, 10'd5,  2'd0, 0, 0, 0, "absj5b");
    relj_en = 1; br_cond = 0; offset = 10'h3FD;    tick(0, 10'd6,  2'd0, 0, 0, 0, "rel_not_taken");
    absj_en = 1; target = 10'd3;                   tick(0, 10'd3,  2'd0, 0, 0, 0, "absj3");
    call_en = 1; target = 10'd20;                  tick(0, 10'd20, 2'd1, 0, 0, 0, "call20");
    call_en = 1; target = 10'd40;                  tick(0, 10'd40, 2'd2, 0, 0, 0, "call40");
    call_en = 1; target = 10'd100;                 tick(0, 10'd41, 2'd2, 1, 0, 0, "call_ovf");
    ret_en = 1;                                    tick(0, 10'd21, 2'd1, 1, 0, 0, "ret1");
    ret_en = 1;                                    tick(0, 10'd4,  2'd0, 1, 0, 0, "ret2");
    absj_en = 1; target = 10'd8;                   tick(0, 10'd8,  2'd0, 1, 0, 0, "absj8");
    ret_en = 1; call_en = 1; absj_en = 1; target = 10'd30;
                                                   tick(0, 10'd9,  2'd0, 1, 1, 0, "priority_unf");
    call_en = 1; target = 10'd7;                   tick(0, 10'd7,  2'd1, 1, 1, 0, "call7");
    for (int k = 0; k < 3; k++) begin
      stall = 1; absj_en = 1; call_en = 1; target = 10'd50;
      tick(0, 10'd7, 2'd1, 1, 1, 0, $sformatf("stall%0d", k));
    end
    mach_code = 9'h1FF; absj_en = 1; target = 10'd50;
                                                   tick(0, 10'd7,  2'd1, 1, 1, 1, "halt");
    absj_en = 1; target = 10'd50;                  tick(0, 10'd7,  2'd1, 1, 1, 1, "frozen_absj");
    ret_en = 1;                                    tick(0, 10'd7,  2'd1, 1, 1, 1, "frozen_ret");

    // Async reset between edges while halted with a stacked entry.
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", {prog_ctr, sp, stack_ovf, stack_unf, done, 1'b0}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    tick(0, 10'd1, 2'd0, 0, 0, 0, "resume1");
    tick(0, 10'd2, 2'd0, 0, 0, 0, "resume2");

    @(posedge clk); #2;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter D, default 10, meaning program counter width in bits.
REQ-002 The block SHALL have parameter W, default 9, meaning machine-code width in bits.
REQ-003 The block SHALL have parameter S, default 4, meaning return-stack depth in entries (S >= 2).
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port stall, input, 1, meaning hold the PC and stack this cycle.
REQ-007 The block SHALL have port mach_code, input, W, meaning the instruction currently fetched at prog_ctr.
REQ-008 The block SHALL have port absj_en, input, 1, meaning absolute jump to target.
REQ-009 The block SHALL have port target, input, D, meaning the absolute jump or call destination.
REQ-010 The block SHALL have port relj_en, input, 1, meaning conditional relative branch request.
REQ-011 The block SHALL have port br_cond, input, 1, meaning registered flag result qualifying relj_en.
REQ-012 The block SHALL have port offset, input, D, meaning two's-complement relative displacement.
REQ-013 The block SHALL have port call_en, input, 1, meaning push return address and jump to target.
REQ-014 The block SHALL have port ret_en, input, 1, meaning pop the return address into the PC.
REQ-015 The block SHALL have port prog_ctr, output, D, meaning the current program counter.
REQ-016 The block SHALL have port sp, output, $clog2(S+1), meaning the number of valid stack entries.
REQ-017 The block SHALL have port stack_ovf, output, 1, meaning sticky call-on-full error.
REQ-018 The block SHALL have port stack_unf, output, 1, meaning sticky return-on-empty error.
REQ-019 The block SHALL have port done, output, 1, meaning sticky halt indication.

Function
REQ-020 Next-PC selection SHALL use fixed priority: done > stall > ret_en > call_en > absj_en > (relj_en & br_cond) > sequential; lower-priority requests in the same cycle SHALL be ignored.
REQ-021 Sequential and all PC arithmetic SHALL be modulo 2^D: PC+1 from all-ones wraps to 0; PC+offset sign-extends offset to D bits and wraps.
REQ-022 relj_en with br_cond=0 SHALL advance to PC+1.
REQ-023 absj_en SHALL load target the next cycle; latency is one clock for every redirect.
REQ-024 call_en with sp<S SHALL write PC+1 (wrapped) at entry sp, increment sp, and load target.
REQ-025 call_en with sp==S SHALL not push and not jump, SHALL advance to PC+1, and SHALL set stack_ovf.
REQ-026 ret_en with sp>0 SHALL load entry sp-1 into the PC and decrement sp.
REQ-027 ret_en with sp==0 SHALL advance to PC+1 and SHALL set stack_unf.
REQ-028 While stall=1 (and done=0), prog_ctr, sp, stack contents and error flags SHALL hold; all requests SHALL be ignored.
REQ-029 done SHALL set on the rising edge where mach_code is all ones, stall=0 and done=0; the PC SHALL hold at the halt address from that edge.
REQ-030 Once done=1, prog_ctr, sp and the stack SHALL freeze and all inputs SHALL be ignored until reset.
REQ-031 stack_ovf and stack_unf SHALL remain set until reset.
REQ-032 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-033 reset=0 SHALL immediately, independent of clk, force prog_ctr=0, sp=0, stack_ovf=0, stack_unf=0 and done=0.
REQ-034 Stack entry contents SHALL be don't-care after reset; sp=0 SHALL make them unreachable.
REQ-035 Deassertion of reset mid-program SHALL restart execution at address 0 on the first subsequent rising edge with PC+1 semantics.

Verification
REQ-036 The bench SHALL verify sequential wrap: with D=4, run 17 plain cycles from reset -> prog_ctr sequence 0..15 then 0.
REQ-037 The bench SHALL verify relative branching: at PC=5 with relj_en=1, br_cond=1, offset=-3 -> PC=2; repeated with br_cond=0 -> PC=6.
REQ-038 The bench SHALL verify nested calls: with S=2, call to 20 from 3, then call to 40 from 20, then a third call from 40 -> stack_ovf=1, PC=41, sp=2; two rets -> PC=21 then PC=4.
REQ-039 The bench SHALL verify priority: at PC=8 with ret_en, call_en and absj_en all asserted and sp=0 -> stack_unf=1, PC=9, sp=0.
REQ-040 The bench SHALL verify stall and halt: stall held 3 cycles at PC=7 -> PC stays 7; then mach_code=all ones -> done=1 on that edge, PC frozen at 7 despite absj_en.
REQ-041 The bench SHALL verify async reset: assert reset between clock edges while done=1, sp=1 -> all outputs cleared before the next edge; resumes from 0.
